// File: rtl/control_setup_initiator.sv
// Host-side control-transfer initiator: serializes an 8-byte SETUP packet, runs the OUT/IN data stage, then waits for the status handshake.
// Optional macro CTRL_TIMEOUT_EN aborts DATA_IN/STATUS after TIMEOUT_CYCLES idle cycles.
module control_setup_initiator #(
    parameter int unsigned MAX_DATA_BYTES = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  bmRequestType,
    input  logic [7:0]  bRequest,
    input  logic [15:0] wValue,
    input  logic [15:0] wIndex,
    input  logic [15:0] wLength,
    input  logic [63:0] out_payload,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        hs_ack,
    input  logic        hs_stall,
    output logic [63:0] setup_word,
    output logic [63:0] in_payload,
    output logic [15:0] xfer_count,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    localparam int unsigned LEN_W = 4;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_DATA_OUT, S_DATA_IN, S_STATUS, S_DONE, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [7:0]        tx_data_d;
    logic              tx_valid_d;
    logic [63:0]       setup_word_d;
    logic [63:0]       in_payload_d;
    logic [15:0]       xfer_count_d;
    logic              busy_d, done_d, stall_d;
    logic [15:0]       nxt_cnt;

`ifdef CTRL_TIMEOUT_EN
    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TIMER_W-1:0] timer_q, timer_d;
`endif

    // Wire order of the SETUP packet: 16-bit fields go out low byte first.
    function automatic logic [7:0] setup_byte(input logic [63:0] word, input logic [2:0] i);
        case (i)
            3'd0:    setup_byte = word[63:56];
            3'd1:    setup_byte = word[55:48];
            3'd2:    setup_byte = word[39:32];
            3'd3:    setup_byte = word[47:40];
            3'd4:    setup_byte = word[23:16];
            3'd5:    setup_byte = word[31:24];
            3'd6:    setup_byte = word[7:0];
            default: setup_byte = word[15:8];
        endcase
    endfunction

    assign nxt_cnt = xfer_count + 16'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            setup_word <= '0;
            in_payload <= '0;
            xfer_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            stall      <= 1'b0;
`ifdef CTRL_TIMEOUT_EN
            timer_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            tx_data    <= tx_data_d;
            tx_valid   <= tx_valid_d;
            setup_word <= setup_word_d;
            in_payload <= in_payload_d;
            xfer_count <= xfer_count_d;
            busy       <= busy_d;
            done       <= done_d;
            stall      <= stall_d;
`ifdef CTRL_TIMEOUT_EN
            timer_q    <= timer_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        len_d        = len_q;
        tx_data_d    = tx_data;
        tx_valid_d   = tx_valid;
        setup_word_d = setup_word;
        in_payload_d = in_payload;
        xfer_count_d = xfer_count;
        busy_d       = busy;
        done_d       = 1'b0;
        stall_d      = 1'b0;
`ifdef CTRL_TIMEOUT_EN
        timer_d      = '0;
`endif
        case (state_q)
            S_IDLE: begin
                tx_valid_d = 1'b0;
                if (start) begin
                    setup_word_d = {bmRequestType, bRequest, wValue, wIndex, wLength};
                    if (wLength > 16'(MAX_DATA_BYTES)) len_d = LEN_W'(MAX_DATA_BYTES);
                    else                               len_d = LEN_W'(wLength);
                    in_payload_d = '0;
                    xfer_count_d = '0;
                    busy_d       = 1'b1;
                    idx_d        = '0;
                    tx_valid_d   = 1'b1;
                    tx_data_d    = bmRequestType;
                    state_d      = S_SETUP;
                end
            end
            S_SETUP: begin
                if (tx_ready) begin
                    if (idx_q == 3'd7) begin
                        tx_valid_d = 1'b0;
                        if (len_q == '0) begin
                            state_d = S_STATUS;
                        end else if (setup_word[63]) begin
                            state_d = S_DATA_IN;
                        end else begin
                            state_d    = S_DATA_OUT;
                            tx_valid_d = 1'b1;
                            tx_data_d  = out_payload[7:0];
                        end
                    end else begin
                        idx_d     = idx_q + 3'd1;
                        tx_data_d = setup_byte(setup_word, idx_q + 3'd1);
                    end
                end
            end
            S_DATA_OUT: begin
                if (hs_stall) begin
                    state_d    = S_ERR;
                    stall_d    = 1'b1;
                    tx_valid_d = 1'b0;
                end else if (tx_ready) begin
                    xfer_count_d = nxt_cnt;
                    if (nxt_cnt == 16'(len_q)) begin
                        state_d    = S_STATUS;
                        tx_valid_d = 1'b0;
                    end else begin
                        tx_data_d = out_payload[{nxt_cnt[2:0], 3'b000} +: 8];
                    end
                end
            end
            S_DATA_IN: begin
                if (hs_stall) begin
                    state_d = S_ERR;
                    stall_d = 1'b1;
                end else if (rx_valid) begin
                    in_payload_d[{xfer_count[2:0], 3'b000} +: 8] = rx_data;
                    xfer_count_d = nxt_cnt;
                    if (nxt_cnt == 16'(len_q)) state_d = S_STATUS;
                end else begin
`ifdef CTRL_TIMEOUT_EN
                    if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d = S_ERR;
                        stall_d = 1'b1;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
`endif
                end
            end
            S_STATUS: begin
                // Stall wins when both handshakes arrive together.
                if (hs_stall) begin
                    state_d = S_ERR;
                    stall_d = 1'b1;
                end else if (hs_ack) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
`ifdef CTRL_TIMEOUT_EN
                    if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d = S_ERR;
                        stall_d = 1'b1;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
`endif
                end
            end
            S_DONE, S_ERR: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_setup_initiator.sv
// Directed self-checking bench for control_setup_initiator (MAX_DATA_BYTES=4, TIMEOUT_CYCLES=10).
module tb_control_setup_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  bmRequestType, bRequest;
    logic [15:0] wValue, wIndex, wLength;
    logic [63:0] out_payload;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid, hs_ack, hs_stall;
    logic [63:0] setup_word, in_payload;
    logic [15:0] xfer_count;
    logic        busy, done, stall;

    int n_checks = 0;
    int n_fail   = 0;

    control_setup_initiator #(.MAX_DATA_BYTES(4), .TIMEOUT_CYCLES(10)) dut (
        .clk(clk), .rst(rst), .start(start),
        .bmRequestType(bmRequestType), .bRequest(bRequest), .wValue(wValue),
        .wIndex(wIndex), .wLength(wLength), .out_payload(out_payload),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .hs_ack(hs_ack), .hs_stall(hs_stall),
        .setup_word(setup_word), .in_payload(in_payload), .xfer_count(xfer_count),
        .busy(busy), .done(done), .stall(stall)
    );

    always #5 clk = ~clk;

    // Drives a request and pulses start; returns at the negedge where the first SETUP byte is visible.
    task automatic launch(input logic [7:0] bm, input logic [7:0] br, input logic [15:0] wv,
                          input logic [15:0] wi, input logic [15:0] wl, input logic [63:0] pl);
        bmRequestType = bm; bRequest = br; wValue = wv; wIndex = wi; wLength = wl;
        out_payload = pl; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // With tx_ready held high, records every byte until tx_valid drops (bounded).
    task automatic collect_tx(output int n, output logic [127:0] b);
        n = 0; b = '0;
        for (int c = 0; c < 60; c++) begin
            if (!tx_valid || n >= 16) break;
            b[8*n +: 8] = tx_data;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({tx_valid, busy, done, stall} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000", {tx_valid, busy, done, stall});
        end
        n_checks++;
        if ({setup_word, in_payload, xfer_count, tx_data} !== 152'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h/%h/%h expected all zero", setup_word, in_payload, xfer_count, tx_data);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        tx_ready = 1'b1;
        launch(8'h21, 8'h0A, 16'h0, 16'h0, 16'h2, 64'hBEEF);
        for (int c = 0; c < 40; c++) begin
            if (tx_valid) seen++;
            if (seen == 9) break;
            @(negedge clk);
        end
        n_checks++;
        if (seen != 9) begin
            n_fail++;
            $display("FAIL reset_mid_reach: got %0d bytes expected 9", seen);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({tx_valid, busy, done, stall, setup_word, in_payload, xfer_count, tx_data} !== 156'h0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got busy=%b tx_valid=%b setup=%h xfer=%h expected all zero",
                     busy, tx_valid, setup_word, xfer_count);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, tx_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid_idle: got %b expected 00", {busy, tx_valid});
        end
    endtask

    task automatic test_out;
        int n;
        logic [127:0] b;
        tx_ready = 1'b1;
        launch(8'h21, 8'h0A, 16'h0000, 16'h0000, 16'h0002, 64'hBEEF);
        collect_tx(n, b);
        n_checks++;
        if (n != 10 || b[79:0] !== 80'hBEEF_0002_0000_0000_0A21) begin
            n_fail++;
            $display("FAIL out_bytes: got n=%0d %h expected n=10 beef0002000000000a21", n, b[79:0]);
        end
        n_checks++;
        if (setup_word !== 64'h210A_0000_0000_0002) begin
            n_fail++;
            $display("FAIL out_setup_word: got %h expected 210a000000000002", setup_word);
        end
        n_checks++;
        if (xfer_count !== 16'd2 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL out_count: got xfer=%0d busy=%b expected 2 1", xfer_count, busy);
        end
        hs_ack = 1'b1;
        @(negedge clk);
        hs_ack = 1'b0;
        n_checks++;
        if ({done, busy, stall} !== 3'b110) begin
            n_fail++;
            $display("FAIL out_done: got %b expected 110", {done, busy, stall});
        end
        @(negedge clk);
        n_checks++;
        if ({done, busy, xfer_count} !== {2'b00, 16'd2}) begin
            n_fail++;
            $display("FAIL out_after: got done=%b busy=%b xfer=%0d expected 0 0 2", done, busy, xfer_count);
        end
    endtask

    task automatic test_in;
        int n;
        logic [127:0] b;
        logic [31:0] rx_bytes = 32'h0200_0112;
        tx_ready = 1'b1;
        launch(8'h80, 8'h06, 16'h0100, 16'h0000, 16'h0012, 64'h0);
        collect_tx(n, b);
        n_checks++;
        if (n != 8 || b[63:0] !== 64'h0012_0000_0100_0680) begin
            n_fail++;
            $display("FAIL in_setup_bytes: got n=%0d %h expected n=8 0012000001000680", n, b[63:0]);
        end
        for (int i = 0; i < 4; i++) begin
            rx_data = rx_bytes[8*i +: 8];
            rx_valid = 1'b1;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        n_checks++;
        if (in_payload !== 64'h0000_0000_0200_0112 || xfer_count !== 16'd4) begin
            n_fail++;
            $display("FAIL in_payload: got %h xfer=%0d expected 0000000002000112 4", in_payload, xfer_count);
        end
        n_checks++;
        if ({busy, tx_valid, done} !== 3'b100) begin
            n_fail++;
            $display("FAIL in_wait_status: got %b expected 100", {busy, tx_valid, done});
        end
        hs_ack = 1'b1;
        @(negedge clk);
        hs_ack = 1'b0;
        n_checks++;
        if ({done, stall} !== 2'b10) begin
            n_fail++;
            $display("FAIL in_done: got %b expected 10", {done, stall});
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        logic [87:0] exp_bytes = 88'h332211_0003_5678_1234_0140;
        logic [3:0]  pat = 4'b1001;
        int ptr = 0;
        tx_ready = 1'b0;
        launch(8'h40, 8'h01, 16'h1234, 16'h5678, 16'h0003, 64'h0000_0000_0033_2211);
        for (int c = 0; c < 100; c++) begin
            if (ptr == 11) break;
            n_checks++;
            if ({tx_valid, tx_data} !== {1'b1, exp_bytes[8*ptr +: 8]}) begin
                n_fail++;
                $display("FAIL bp_byte%0d: got valid=%b data=%h expected 1 %h", ptr, tx_valid, tx_data, exp_bytes[8*ptr +: 8]);
            end
            tx_ready = pat[c % 4];
            if (tx_ready) ptr++;
            @(negedge clk);
        end
        tx_ready = 1'b1;
        n_checks++;
        if (ptr != 11 || tx_valid !== 1'b0 || xfer_count !== 16'd3) begin
            n_fail++;
            $display("FAIL bp_end: got ptr=%0d valid=%b xfer=%0d expected 11 0 3", ptr, tx_valid, xfer_count);
        end
        hs_ack = 1'b1;
        @(negedge clk);
        hs_ack = 1'b0;
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_done: got %b expected 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_stall_status;
        int n;
        logic [127:0] b;
        tx_ready = 1'b1;
        launch(8'h00, 8'h09, 16'h0001, 16'h0000, 16'h0000, 64'h0);
        collect_tx(n, b);
        n_checks++;
        if (n != 8) begin
            n_fail++;
            $display("FAIL st_setup_len: got %0d expected 8", n);
        end
        hs_ack = 1'b1; hs_stall = 1'b1;
        @(negedge clk);
        hs_ack = 1'b0; hs_stall = 1'b0;
        n_checks++;
        if ({stall, done, busy} !== 3'b101) begin
            n_fail++;
            $display("FAIL st_pulse: got %b expected 101", {stall, done, busy});
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({stall, done, busy, tx_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL st_after: got %b expected 0000", {stall, done, busy, tx_valid});
        end
        @(negedge clk);
        n_checks++;
        if ({busy, tx_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL st_start_ignored: got %b expected 00", {busy, tx_valid});
        end
    endtask

    task automatic test_stall_data;
        int seen = 0;
        tx_ready = 1'b1;
        launch(8'h21, 8'h0A, 16'h0, 16'h0, 16'h0004, 64'h4433_2211);
        for (int c = 0; c < 40; c++) begin
            if (tx_valid) seen++;
            if (seen == 10) break;
            @(negedge clk);
        end
        tx_ready = 1'b0; hs_stall = 1'b1;
        @(negedge clk);
        hs_stall = 1'b0; tx_ready = 1'b1;
        n_checks++;
        if ({stall, done, busy, tx_valid} !== 4'b1010 || xfer_count !== 16'd1) begin
            n_fail++;
            $display("FAIL sd_pulse: got flags=%b xfer=%0d expected 1010 1", {stall, done, busy, tx_valid}, xfer_count);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || xfer_count !== 16'd1) begin
            n_fail++;
            $display("FAIL sd_hold: got busy=%b xfer=%0d expected 0 1", busy, xfer_count);
        end
    endtask

    task automatic test_timeout;
        int n;
        logic [127:0] b;
        tx_ready = 1'b1;
        launch(8'h00, 8'h05, 16'h0007, 16'h0000, 16'h0000, 64'h0);
        collect_tx(n, b);
        n_checks++;
        if (n != 8) begin
            n_fail++;
            $display("FAIL to_setup_len: got %0d expected 8", n);
        end
`ifdef CTRL_TIMEOUT_EN
        begin
            logic early = 1'b0;
            for (int i = 1; i < 10; i++) begin
                @(negedge clk);
                if (stall) early = 1'b1;
            end
            @(negedge clk);
            n_checks++;
            if (early || stall !== 1'b1) begin
                n_fail++;
                $display("FAIL to_pulse: got early=%b stall=%b expected 0 1", early, stall);
            end
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL to_idle: got busy=%b expected 0", busy);
            end
        end
`else
        repeat (30) @(negedge clk);
        n_checks++;
        if ({busy, stall, done} !== 3'b100) begin
            n_fail++;
            $display("FAIL to_wait: got %b expected 100", {busy, stall, done});
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
`endif
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; bmRequestType = '0; bRequest = '0; wValue = '0; wIndex = '0;
        wLength = '0; out_payload = '0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
        hs_ack = 1'b0; hs_stall = 1'b0;
        @(negedge clk);
        test_reset;
        test_reset_mid;
        test_out;
        test_in;
        test_backpressure;
        test_stall_status;
        test_stall_data;
        test_timeout;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
